red_pitaya_sys_master: RTL and testbench

RED_PITAYA_SYS_MASTER -- requirements
Module: red_pitaya_sys_master

---
 rtl/red_pitaya_sys_master.sv | 161 ++++++++++++++++
 tb/tb_red_pitaya_sys_master.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_sys_master.sv
// Single-outstanding command-to-system-bus master: strobe, wait for ack/err, return one response.
// Optional WAIT abort counter is built only when SYS_MASTER_TIMEOUT_EN is defined.
module red_pitaya_sys_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic [31:0] sys_addr_o,
  output logic [31:0] sys_wdata_o,
  output logic [3:0]  sys_sel_o,
  output logic        sys_wen_o,
  output logic        sys_ren_o,
  input  logic [31:0] sys_rdata_i,
  input  logic        sys_err_i,
  input  logic        sys_ack_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        to_q, to_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        wen_q, wen_d;
  logic        ren_q, ren_d;
  logic        valid_q, valid_d;

`ifdef SYS_MASTER_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    to_d    = to_q;
`ifdef SYS_MASTER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid_i && ready_q) begin
          we_d    = cmd_we_i;
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          sel_d   = cmd_sel_i;
          state_d = STROBE;
        end
      end
      STROBE: begin
        state_d = WAIT;
`ifdef SYS_MASTER_TIMEOUT_EN
        cnt_d   = 16'd0;
`endif
      end
      WAIT: begin
        // A responder answer on the last counted cycle still wins over the abort.
        if (sys_ack_i || sys_err_i) begin
          state_d = RESP;
          err_d   = sys_err_i;
          to_d    = 1'b0;
          rdata_d = (!we_q && sys_ack_i && !sys_err_i) ? sys_rdata_i : 32'd0;
        end
`ifdef SYS_MASTER_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          err_d   = 1'b0;
          to_d    = 1'b1;
          rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    wen_d   = (state_d == STROBE) && we_d;
    ren_d   = (state_d == STROBE) && !we_d;
    valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      sel_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef SYS_MASTER_TIMEOUT_EN
      cnt_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      to_q    <= to_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      valid_q <= valid_d;
`ifdef SYS_MASTER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign cmd_ready_o   = ready_q;
  assign busy_o        = busy_q;
  assign sys_addr_o    = addr_q;
  assign sys_wdata_o   = wdata_q;
  assign sys_sel_o     = sel_q;
  assign sys_wen_o     = wen_q;
  assign sys_ren_o     = ren_q;
  assign rsp_valid_o   = valid_q;
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign rsp_timeout_o = to_q;

endmodule

// File: tb/tb_red_pitaya_sys_master.sv
// Scoreboard bench for red_pitaya_sys_master; the timeout case follows SYS_MASTER_TIMEOUT_EN.
module tb_red_pitaya_sys_master;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o, rsp_timeout_o;
  logic [31:0] sys_addr_o, sys_wdata_o;
  logic [3:0]  sys_sel_o;
  logic        sys_wen_o, sys_ren_o;
  logic [31:0] sys_rdata_i;
  logic        sys_err_i, sys_ack_i;
  logic        busy_o;

  red_pitaya_sys_master #(.TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .sys_addr_o(sys_addr_o), .sys_wdata_o(sys_wdata_o), .sys_sel_o(sys_sel_o),
    .sys_wen_o(sys_wen_o), .sys_ren_o(sys_ren_o),
    .sys_rdata_i(sys_rdata_i), .sys_err_i(sys_err_i), .sys_ack_i(sys_ack_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks  = 0;
  int   errors  = 0;
  int   strobes = 0;
  bit   prev_v  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation at each new response, re-checks fields at the handshake.
  always @(negedge clk) begin
    if (rst_i) begin
      prev_v <= 1'b0;
    end else begin
      if (rsp_valid_o && !prev_v) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid_o), 32'd0);
        end else begin
          cur = sb.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(cur.cyc));
          chk("rsp_rdata", rsp_rdata_o, cur.rdata);
          chk("rsp_err", 32'(rsp_err_o), 32'(cur.err));
          chk("rsp_timeout", 32'(rsp_timeout_o), 32'(cur.to));
        end
      end
      if (rsp_valid_o && rsp_ready_i && prev_v) begin
        chk("hold_rdata", rsp_rdata_o, cur.rdata);
        chk("hold_err", 32'(rsp_err_o), 32'(cur.err));
        chk("hold_timeout", 32'(rsp_timeout_o), 32'(cur.to));
      end
      if (sys_wen_o && sys_ren_o) chk("wen_ren_both", 32'd1, 32'd0);
      if (sys_wen_o || sys_ren_o) strobes++;
      prev_v <= rsp_valid_o;
    end
  end

  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] sel, input int k, input logic ack, input logic err,
                     input logic [31:0] rdata, input logic [31:0] exp_rdata,
                     input logic exp_err, input logic exp_to, input int exp_lat,
                     input int hold, input bit stray);
    int n;
    int s0;
    exp_t e;
    @(posedge clk); #1;
    rsp_ready_i = (hold == 0);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_wdata_i = wdata; cmd_sel_i = sel;
    n = 0;
    @(negedge clk);
    while (!cmd_ready_o && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready", 32'(cmd_ready_o), 32'd1);
    @(posedge clk); #1;
    s0 = strobes;
    cmd_valid_i = 1'b0; cmd_addr_i = ~addr; cmd_wdata_i = ~wdata; cmd_sel_i = ~sel;
    if (stray) begin sys_ack_i = 1'b1; sys_rdata_i = 32'h5555_5555; end
    @(negedge clk);
    e.rdata = exp_rdata; e.err = exp_err; e.to = exp_to; e.cyc = cyc + exp_lat;
    sb.push_back(e);
    chk("strobe_wen", 32'(sys_wen_o), 32'(we));
    chk("strobe_ren", 32'(sys_ren_o), 32'(!we));
    chk("sys_addr", sys_addr_o, addr);
    chk("sys_wdata", sys_wdata_o, wdata);
    chk("sys_sel", 32'(sys_sel_o), 32'(sel));
    @(posedge clk); #1;
    sys_ack_i = 1'b0;
    if (k > 0) begin
      repeat (k - 1) begin @(posedge clk); #1; end
      sys_ack_i = ack; sys_err_i = err; sys_rdata_i = rdata;
      @(posedge clk); #1;
      sys_ack_i = 1'b0; sys_err_i = 1'b0; sys_rdata_i = 32'd0;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid_o && n < 2000);
    chk("rsp_wait", 32'(rsp_valid_o), 32'd1);
    if (hold > 0) begin
      @(posedge clk); #1;
      cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 32'h44;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("ready_in_resp", 32'(cmd_ready_o), 32'd0);
        chk("valid_held", 32'(rsp_valid_o), 32'd1);
        @(posedge clk); #1;
      end
      cmd_valid_i = 1'b0; rsp_ready_i = 1'b1;
      @(negedge clk);
    end
    n = 0;
    while (!(rsp_valid_o && rsp_ready_i) && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("idle_after_hs", 32'(cmd_ready_o), 32'd1);
    chk("valid_after_hs", 32'(rsp_valid_o), 32'd0);
    #1;
    chk("strobe_count", 32'(strobes), 32'(s0 + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
    cmd_sel_i = '0; rsp_ready_i = 1'b1; sys_rdata_i = '0; sys_err_i = 1'b0; sys_ack_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_strobe", 32'(sys_wen_o | sys_ren_o), 32'd0);
    chk("rst_addr", sys_addr_o, 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready_o), 32'd1);

    txn(1'b1, 32'h30, 32'h0000_005A, 4'hF, 1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 2, 0, 1'b0);
    txn(1'b0, 32'h0C, 32'd0, 4'hF, 3, 1'b1, 1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 4, 0, 1'b1);
    txn(1'b0, 32'h20, 32'd0, 4'hF, 2, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 3, 0, 1'b0);
    txn(1'b1, 32'h24, 32'h1234_5678, 4'h3, 1, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0, 2, 0, 1'b0);
    txn(1'b0, 32'h08, 32'd0, 4'hF, 1, 1'b1, 1'b0, 32'hA5A5_1234, 32'hA5A5_1234, 1'b0, 1'b0, 2, 5, 1'b0);
    txn(1'b0, 32'h40, 32'd0, 4'hF, 16, 1'b1, 1'b0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1'b0, 17, 0, 1'b0);
`ifdef SYS_MASTER_TIMEOUT_EN
    txn(1'b1, 32'h50, 32'h77, 4'hF, 0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 17, 0, 1'b0);
`else
    txn(1'b0, 32'h50, 32'd0, 4'hF, 1001, 1'b1, 1'b0, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0, 1'b0, 1002, 0, 1'b0);
`endif

    // Reset while waiting, then a late ack that must be ignored.
    @(posedge clk); #1;
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h10;
    n = 0;
    @(negedge clk);
    while (!cmd_ready_o && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0; sys_ack_i = 1'b1; sys_rdata_i = 32'h0000_1234;
    @(negedge clk);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_addr", sys_addr_o, 32'd0);
    chk("midrst_valid", 32'(rsp_valid_o), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    sys_ack_i = 1'b0; sys_rdata_i = 32'd0;
    repeat (4) begin
      @(negedge clk);
      chk("late_ack_valid", 32'(rsp_valid_o), 32'd0);
      chk("late_ack_busy", 32'(busy_o), 32'd0);
    end

    txn(1'b0, 32'h0C, 32'd0, 4'hF, 1, 1'b1, 1'b0, 32'h0000_0042, 32'h0000_0042, 1'b0, 1'b0, 2, 0, 1'b0);

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
